// File: rtl/fp16_exp_align_unit.sv
// FP16 exponent alignment. Takes the exponent difference from the subtractor,
// picks the larger operand and right-shifts the smaller significand one bit
// per cycle while folding shifted-out bits into a sticky LSB.
module fp16_exp_align_unit #(
   parameter int MANT_W = 11,
   parameter int EXP_W  = 5,
   parameter int GRS_W  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W-1:0]        diff_mag,
   input  logic                    diff_neg,
   input  logic [EXP_W-1:0]        exp_a,
   input  logic [EXP_W-1:0]        exp_b,
   input  logic [MANT_W-1:0]       mant_a,
   input  logic [MANT_W-1:0]       mant_b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W-1:0]        out_exp,
   output logic [MANT_W+GRS_W-1:0] out_mant_big,
   output logic [MANT_W+GRS_W-1:0] out_mant_small,
   output logic                    out_swap,
   output logic                    busy
);
   localparam int W = MANT_W + GRS_W;
   // Shifting by W or more leaves only the sticky bit, so skip the walk.
   localparam logic [EXP_W-1:0] SAT = EXP_W'(W);
   localparam logic [EXP_W-1:0] ONE = EXP_W'(1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state, state_nxt;
   logic [EXP_W-1:0]  cnt;
   logic [W-1:0]      big_r, small_r;
   logic [EXP_W-1:0]  exp_r;
   logic              swap_r;
   logic [MANT_W-1:0] sel_big, sel_small;
   logic [EXP_W-1:0]  sel_exp;

   // Operand selection: borrow means B is larger; ties fall to A.
   always_comb begin
      sel_big   = diff_neg ? mant_b : mant_a;
      sel_small = diff_neg ? mant_a : mant_b;
      sel_exp   = diff_neg ? exp_b  : exp_a;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) begin
            if (diff_mag == '0 || diff_mag >= SAT) state_nxt = DONE;
            else                                   state_nxt = SHIFT;
         end
         SHIFT: if (cnt == ONE) state_nxt = DONE;
         DONE:  if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: load on accept, shift with sticky fold, hold in DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         big_r   <= '0;
         small_r <= '0;
         exp_r   <= '0;
         swap_r  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               cnt    <= diff_mag;
               big_r  <= {sel_big, {GRS_W{1'b0}}};
               exp_r  <= sel_exp;
               swap_r <= diff_neg;
               if (diff_mag >= SAT) small_r <= {{(W-1){1'b0}}, |sel_small};
               else                 small_r <= {sel_small, {GRS_W{1'b0}}};
            end
            SHIFT: begin
               small_r <= {1'b0, small_r[W-1:2], small_r[1] | small_r[0]};
               cnt     <= cnt - ONE;
            end
            default: ;
         endcase
      end
   end

   assign in_ready       = (state == IDLE);
   assign out_valid      = (state == DONE);
   assign busy           = (state != IDLE);
   assign out_exp        = exp_r;
   assign out_mant_big   = big_r;
   assign out_mant_small = small_r;
   assign out_swap       = swap_r;
endmodule

// File: doc/fp16_exp_align_unit.md
Name: fp16_exp_align_unit

Overview:
- Consumer end of the exponent-difference path in the FP16 MAC datapath.
- Takes the exponent-difference magnitude and the borrow/sign flag from the exponent subtractor, together with both operands' exponents and significands.
- Selects the larger operand and right-shifts the smaller significand, one bit per cycle, with guard/round/sticky tracking.
- Presents the aligned pair to the significand adder over a valid/ready handshake.

Parameters:
- MANT_W, 11, significand width including the hidden bit.
- EXP_W, 5, exponent and difference-magnitude width.
- GRS_W, 3, extra low-order bits appended for guard, round and sticky.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input bundle valid.
- in_ready  out  1  block can accept an input bundle.
- diff_mag  in  EXP_W  |exp_a - exp_b|, as produced by the subtractor.
- diff_neg  in  1  borrow flag; 1 means exp_a < exp_b.
- exp_a  in  EXP_W  exponent of operand A.
- exp_b  in  EXP_W  exponent of operand B.
- mant_a  in  MANT_W  significand of A, hidden bit included.
- mant_b  in  MANT_W  significand of B, hidden bit included.
- out_valid  out  1  aligned result valid.
- out_ready  in  1  downstream accepts the result.
- out_exp  out  EXP_W  exponent of the larger operand.
- out_mant_big  out  MANT_W+GRS_W  larger significand, i.e. {mant, GRS_W'b0}.
- out_mant_small  out  MANT_W+GRS_W  aligned smaller significand; bit 0 is sticky.
- out_swap  out  1  1 when B was selected as the larger operand.
- busy  out  1  high in the SHIFT or DONE state.

Behaviour:
- Reset:
  - Reset is synchronous and active-high: while rst is sampled high, the state goes to IDLE.
  - out_valid, out_exp, out_mant_big, out_mant_small, out_swap and busy are all 0.
  - in_ready = 1 in the cycle after reset; inputs presented while rst is high are ignored.
  - Reset in SHIFT or DONE aborts the operation, with no partial output.
- States:
  - IDLE: in_ready = 1.
  - SHIFT: in_ready = 0, out_valid = 0.
  - DONE: out_valid = 1, in_ready = 0.
- Accept (IDLE with in_valid = 1):
  - diff_neg = 0: big = mant_a, small = mant_b, out_exp = exp_a, out_swap = 0. Ties (diff_mag = 0) select A.
  - diff_neg = 1: big = mant_b, small = mant_a, out_exp = exp_b, out_swap = 1.
  - Both significands are extended to {mant, 000}.
  - The shift counter is loaded with diff_mag.
  - The block trusts diff_mag and diff_neg and does not cross-check them against exp_a/exp_b.
- Transition after accept:
  - diff_mag = 0: go to DONE.
  - diff_mag >= MANT_W+GRS_W (14): saturate. small = {13'b0, |small_ext}, then go to DONE.
  - 1..13: go to SHIFT.
- SHIFT step, applied each cycle:
  - small <= {1'b0, small[13:1]}, with new bit 0 = small[1] | small[0].
  - The counter decrements; go to DONE when it reaches 0.
- Latency:
  - Accept in cycle N; out_valid rises at N+1 for diff 0 or the saturated case.
  - out_valid rises at N+1+diff_mag for diff 1..13.
- DONE:
  - All outputs are held stable while out_ready = 0.
  - When out_ready = 1, the result transfers and the block returns to IDLE in the next cycle, where out_valid = 0 and in_ready = 1.
  - There is no same-cycle re-accept.
- in_valid outside IDLE is ignored. Inputs only need to be stable in the accept cycle.
- busy = (state != IDLE).

Test Plan:
- Equal exponents: diff_mag=0, diff_neg=0, exp_a=exp_b=15, mant_a=0x400, mant_b=0x600 -> out_valid at N+1; big=0x2000, small=0x3000, exp=15, swap=0.
- Swap with shift: diff_neg=1, diff_mag=3, exp_a=12, exp_b=15, mant_a=0x7FF, mant_b=0x400 -> out_valid at N+4; swap=1, exp=15, big=0x2000, small=0x07FF (sticky set).
- Boundary shift: diff_mag=13, diff_neg=0, mant_b=0x400 -> out_valid at N+14; small=0x0001. With diff_mag=12, same operands -> small=0x0002 at N+13.
- Saturation: diff_mag=20, mant_b=0x401 -> out_valid at N+1, small=0x0001. With diff_mag=31 and mant_b=0 -> small=0x0000.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new data -> outputs unchanged, in_ready=0, new data not taken. Then out_ready=1 -> out_valid=0 and in_ready=1 the next cycle.
- Reset mid-SHIFT: diff_mag=10, assert rst at N+4 -> following cycle state IDLE, out_valid=0, all outputs 0, in_ready=1; a subsequent diff_mag=0 transaction completes correctly.
